// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// The ALU opcodes here must match the integer ALU decoder.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;

endpackage

// File: rtl/mul_sequencer_if.sv
// Handshake and shared-ALU bus between the core, the multiply sequencer
// and the integer ALU. The sequencer uses the slave modport; the core-side
// controller (and the ALU hookup) uses the master modport.
interface mul_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);

  logic                     start;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic [DATA_WIDTH-1:0]    alu_src_a;
  logic [DATA_WIDTH-1:0]    alu_src_b;
  logic [OPCODE_LENGTH-1:0] alu_operation;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport slave (
    input  start, op_a, op_b, alu_result,
    output busy, done, result, alu_src_a, alu_src_b, alu_operation
  );

  modport master (
    output start, op_a, op_b, alu_result,
    input  busy, done, result, alu_src_a, alu_src_b, alu_operation
  );

endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-and-add multiplier (low DATA_WIDTH bits of the product)
// that borrows the shared integer ALU for its additions.
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to stop as soon as the
// remaining multiplier bits are all zero; otherwise latency is fixed at
// DATA_WIDTH RUN cycles so pipeline stall counts stay deterministic.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; ALU bus held quiet
// RUN   | one shift-and-add iteration per cycle through the shared ALU
// DONE  | one-cycle done pulse; start here begins the next multiply
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  mul_state_e             r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0]  r_mcand;
  logic [DATA_WIDTH-1:0]  r_mplier;
  logic [CNT_W-1:0]       r_count;

  logic                   w_accept;
  logic                   w_last;
  logic [DATA_WIDTH-1:0]  w_acc_next;

  // A new multiply is accepted only from IDLE or DONE; start in RUN is ignored.
  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // The ALU sum is only taken when the current multiplier bit is set.
  assign w_acc_next = r_mplier[0] ? bus.alu_result : r_acc;

  // Decide whether the current RUN cycle is the final iteration.
`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign w_last = (r_count == LAST_CNT) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_count == LAST_CNT);
`endif

  // ALU bus: acc + mcand while running, AND of zeros otherwise.
  assign bus.alu_src_a     = r_busy ? r_acc   : '0;
  assign bus.alu_src_b     = r_busy ? r_mcand : '0;
  assign bus.alu_operation = r_busy ? OPCODE_LENGTH'(ALU_OP_ADD)
                                    : OPCODE_LENGTH'(ALU_OP_AND);

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

  // Control FSM and datapath; busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_state  <= RUN;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= bus.op_a;
      r_mplier <= bus.op_b;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_W'(1);
          if (w_last) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_acc_next;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-and-add controller that computes the low DATA_WIDTH bits of a product (RISC-V MUL semantics) by sequencing the shared integer ALU. The ALU is instantiated by the parent. This block drives the ALU operand and opcode ports and consumes the ALU result. It sits beside the execute stage and is started by the core's multi-cycle control, which stalls while `busy` is high.

## Interface
- `DATA_WIDTH`, 32: operand, result and ALU width.
- `OPCODE_LENGTH`, 4: width of the ALU operation code.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request to begin a multiply. Sampled only when not busy.
- `op_a`  in  DATA_WIDTH: multiplicand, captured when `start` is accepted.
- `op_b`  in  DATA_WIDTH: multiplier, captured when `start` is accepted.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `result`  out  DATA_WIDTH: last completed product. Held until the next completion.
- `alu_src_a`  out  DATA_WIDTH: drives the ALU's SrcA input.
- `alu_src_b`  out  DATA_WIDTH: drives the ALU's SrcB input.
- `alu_operation`  out  OPCODE_LENGTH: drives the ALU's Operation input.
- `alu_result`  in  DATA_WIDTH: the ALU's ALUResult output, which is combinational.

## Operation
- **State machine**
  - States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE on the last iteration.
  - DONE→RUN on `start`; otherwise DONE→IDLE.
  - `start` in RUN is ignored. Operands are not captured.
- **On accept:** acc←0, mcand←op_a, mplier←op_b, count←0.
- **RUN iteration (one per cycle)**
  - ALU port values: `alu_src_a`=acc, `alu_src_b`=mcand, `alu_operation`=ADD (4'b0010).
  - If mplier[0]=1, acc←alu_result; otherwise acc is unchanged.
  - Then mcand←mcand<<1, mplier←mplier>>1 (logical), count←count+1.
- **Last iteration:** count==DATA_WIDTH-1. On that edge, `result` ← the updated acc value.
- **Outside RUN:** `alu_operation`=AND (4'b0000), `alu_src_a`=`alu_src_b`=0. This keeps the ALU bus quiet.
- **Arithmetic**
  - All adds are modulo 2^DATA_WIDTH; overflow bits are discarded.
  - The low half is identical for signed and unsigned operands, so there is no sign handling.
- **Outputs:** `busy`=(state==RUN); `done`=(state==DONE).
- **Reset values:** state IDLE; `busy`=0, `done`=0, `result`=0; acc, mcand, mplier, count all 0. ALU ports take their idle values.
- **Reset mid-operation:** immediately returns to IDLE. No `done` is produced and `result` is cleared.

## Timing
- `start` is sampled at edge T.
- RUN occupies the cycles after edges T..T+N-1.
- `done`=1 and `result` are valid in the cycle after edge T+N. That is N+1 cycles after `start`.
- N=DATA_WIDTH (32 by default) unless early exit is compiled in.
- Back-to-back operation: `start` held in the DONE cycle begins the next multiply at that edge. `done` still pulses for the finished product.
- The ALU path is combinational within a RUN cycle: acc→ALU→acc is a single-cycle loop.

## Configuration
- Macro: `MUL_SEQ_EARLY_EXIT_EN`.
- **Defined:** RUN also ends on any iteration where the shifted mplier (mplier>>1) is zero. The result is latched on that edge. So N = max(1, index of the highest set bit of op_b + 1). op_b=0 or op_b=1 give N=1.
- **Undefined:** N is always DATA_WIDTH. Latency is fixed, as required for deterministic pipeline stall counts.

## Structure
- Package `mul_seq_pkg` holds:
  - The state enum typedef (IDLE/RUN/DONE).
  - ALU opcode constants ALU_OP_AND=4'b0000 and ALU_OP_ADD=4'b0010, shared with the ALU decoder.
- No sub-module: a counter and a three-state FSM in one module.

## Test plan
- op_a=7, op_b=6, start at T → `done` at T+33, `result`=0x0000002A; `busy` high for exactly 32 cycles.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → `result`=0x00000001. op_a=0x00010000, op_b=0x00010000 → `result`=0x00000000 (wrap-around).
- op_a=0xFFFFFFFD (−3), op_b=5 → `result`=0xFFFFFFF1 (−15).
- `start` re-pulsed with op_a=9 at T+10 of a 7×6 run → ignored; `result`=0x2A at T+33. Second `start` held in the DONE cycle → next product completes 33 cycles later.
- `reset` asserted at T+15 → `busy`, `done` and `result` go to 0 immediately. No `done` pulse follows, and `alu_operation` returns to 4'b0000.
- With `MUL_SEQ_EARLY_EXIT_EN`:
  - op_b=0 → `done` at T+2, `result`=0.
  - op_a=3, op_b=5 → `done` at T+4, `result`=15.
  - Without the macro, both cases complete at T+33.
